// File: rtl/prt_tx_drain.sv
// Drains one PRT slot onto an AXI-Stream style egress port through a small FIFO,
// then releases the slot and reports length/status on a one-cycle done pulse.
module prt_tx_drain #(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_SLOTS     = 2,
   parameter int SLOT_WIDTH    = $clog2(NUM_SLOTS),
   parameter int MAX_FRAME     = 1518,
   parameter int FIFO_DEPTH    = 4,
   parameter int START_TIMEOUT = 16
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  tx_req_valid,
   input  logic [SLOT_WIDTH-1:0] tx_req_slot,
   output logic                  tx_req_ready,
   output logic                  EN_start_reading_prt_entry,
   output logic [SLOT_WIDTH-1:0] start_reading_prt_entry_slot,
   input  logic                  RDY_start_reading_prt_entry,
   output logic                  EN_read_prt_entry,
   input  logic                  RDY_read_prt_entry,
   input  logic [DATA_WIDTH:0]   read_prt_entry,
   output logic                  EN_invalidate_prt_entry,
   output logic [SLOT_WIDTH-1:0] invalidate_prt_entry_slot,
   input  logic                  RDY_invalidate_prt_entry,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   output logic                  tx_done,
   output logic [15:0]           tx_len,
   output logic [1:0]            tx_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(MAX_FRAME + 1);
   localparam int TW = $clog2(START_TIMEOUT + 1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW:0]   MAX_C   = (CW+1)'(MAX_FRAME);
   localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, START, FETCH, FLUSH, INVAL, DONE} state_t;

   state_t                state, state_d;
   logic [SLOT_WIDTH-1:0] slot_q;
   logic [CW-1:0]         rcv_cnt;
   logic [TW-1:0]         to_cnt;
   logic [1:0]            err_q, err_d;
   logic                  err_set;
   logic [15:0]           len_q;
   logic                  inflight;
   logic                  stage_valid;
   logic [DATA_WIDTH-1:0] stage_data;
   logic                  stage_load;

   logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
   logic [DATA_WIDTH:0]   fifo_head;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           fifo_cnt;
   logic                  push, push_last, pop, can_push, fetch_ok, rd_complete;

   assign rd_complete = read_prt_entry[DATA_WIDTH];
   assign fifo_head   = fifo_mem[rd_ptr];
   assign m_tvalid    = (fifo_cnt != '0);
   assign m_tdata     = m_tvalid ? fifo_head[DATA_WIDTH-1:0] : '0;
   assign m_tlast     = m_tvalid & fifo_head[DATA_WIDTH];
   assign pop         = m_tvalid & m_tready;
   assign can_push    = (fifo_cnt != DEPTH_C) | pop;

   // A fetch is only issued if its byte is guaranteed FIFO room and cannot overshoot the frame limit.
   assign fetch_ok = RDY_read_prt_entry
                   & ((fifo_cnt + (AW+1)'(inflight)) < DEPTH_C)
                   & (({1'b0, rcv_cnt} + (CW+1)'(inflight)) < MAX_C);

   assign tx_req_ready                 = (state == IDLE);
   assign tx_done                      = (state == DONE);
   assign tx_len                       = len_q;
   assign tx_err                       = err_q;
   assign start_reading_prt_entry_slot = slot_q;
   assign invalidate_prt_entry_slot    = slot_q;

   always_comb begin
      state_d                    = state;
      push                       = 1'b0;
      push_last                  = 1'b0;
      stage_load                 = 1'b0;
      err_set                    = 1'b0;
      err_d                      = 2'd0;
      EN_start_reading_prt_entry = 1'b0;
      EN_read_prt_entry          = 1'b0;
      EN_invalidate_prt_entry    = 1'b0;
      case (state)
         IDLE: if (tx_req_valid) state_d = START;
         START: begin
            EN_start_reading_prt_entry = 1'b1;
            if (RDY_start_reading_prt_entry) begin
               state_d = FETCH;
            end else if (to_cnt == TO_LAST) begin
               err_set = 1'b1;
               err_d   = 2'd1;
               state_d = DONE;
            end
         end
         FETCH: begin
            // The staged byte is only known to be last once the following word arrives.
            if (inflight && rd_complete) begin
               push      = stage_valid;
               push_last = 1'b1;
               state_d   = FLUSH;
            end else if (inflight) begin
               push              = stage_valid;
               stage_load        = 1'b1;
               EN_read_prt_entry = fetch_ok;
            end else if (stage_valid && ({1'b0, rcv_cnt} == MAX_C)) begin
               if (can_push) begin
                  push      = 1'b1;
                  push_last = 1'b1;
                  err_set   = 1'b1;
                  err_d     = 2'd2;
                  state_d   = FLUSH;
               end
            end else begin
               EN_read_prt_entry = fetch_ok;
            end
         end
         FLUSH: if (fifo_cnt == '0 && !inflight) state_d = INVAL;
         INVAL: begin
            EN_invalidate_prt_entry = 1'b1;
            if (RDY_invalidate_prt_entry) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state       <= IDLE;
         slot_q      <= '0;
         rcv_cnt     <= '0;
         to_cnt      <= '0;
         err_q       <= 2'd0;
         len_q       <= '0;
         inflight    <= 1'b0;
         stage_valid <= 1'b0;
         stage_data  <= '0;
      end else begin
         state    <= state_d;
         inflight <= EN_read_prt_entry;
         if (state == IDLE && tx_req_valid) begin
            slot_q      <= tx_req_slot;
            rcv_cnt     <= '0;
            to_cnt      <= '0;
            err_q       <= 2'd0;
            len_q       <= '0;
            stage_valid <= 1'b0;
         end else begin
            if (state == START) to_cnt <= to_cnt + 1'b1;
            if (err_set) err_q <= err_d;
            if (stage_load) begin
               stage_data  <= read_prt_entry[DATA_WIDTH-1:0];
               stage_valid <= 1'b1;
               rcv_cnt     <= rcv_cnt + 1'b1;
            end else if (push) begin
               stage_valid <= 1'b0;
            end
            if (pop && len_q != 16'hFFFF) len_q <= len_q + 16'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr] <= {push_last, stage_data};
   end

endmodule

// File: tb/tb_prt_tx_drain.sv
// Randomized bench: a PRT/sink model drives the drain, a frame-level reference predicts bytes and status.
module tb_prt_tx_drain;

   localparam int SW   = 1;
   localparam int MAXF = 1518;
   localparam int TOUT = 16;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          tx_req_valid = 1'b0;
   logic [SW-1:0] tx_req_slot = '0;
   logic          tx_req_ready;
   logic          EN_start_reading_prt_entry;
   logic [SW-1:0] start_reading_prt_entry_slot;
   logic          RDY_start_reading_prt_entry = 1'b0;
   logic          EN_read_prt_entry;
   logic          RDY_read_prt_entry = 1'b0;
   logic [8:0]    read_prt_entry = '0;
   logic          EN_invalidate_prt_entry;
   logic [SW-1:0] invalidate_prt_entry_slot;
   logic          RDY_invalidate_prt_entry = 1'b0;
   logic [7:0]    m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b0;
   logic          tx_done;
   logic [15:0]   tx_len;
   logic [1:0]    tx_err;

   always #5 CLK = ~CLK;

   prt_tx_drain dut (
      .CLK(CLK), .RST_N(RST_N),
      .tx_req_valid(tx_req_valid), .tx_req_slot(tx_req_slot), .tx_req_ready(tx_req_ready),
      .EN_start_reading_prt_entry(EN_start_reading_prt_entry),
      .start_reading_prt_entry_slot(start_reading_prt_entry_slot),
      .RDY_start_reading_prt_entry(RDY_start_reading_prt_entry),
      .EN_read_prt_entry(EN_read_prt_entry), .RDY_read_prt_entry(RDY_read_prt_entry),
      .read_prt_entry(read_prt_entry),
      .EN_invalidate_prt_entry(EN_invalidate_prt_entry),
      .invalidate_prt_entry_slot(invalidate_prt_entry_slot),
      .RDY_invalidate_prt_entry(RDY_invalidate_prt_entry),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .tx_done(tx_done), .tx_len(tx_len), .tx_err(tx_err)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]    src [0:1599];
   int            src_len = 0;
   bit            src_complete = 1'b1;
   int            start_delay = 0;
   int            tready_mode = 0;
   int            fidx = 0;
   bit            pend_fetch = 1'b0;
   int            cyc = 0;
   int            n_exp = 0;
   int            exp_err = 0;
   int            exp_inv = 0;
   int            beat_idx = 0;
   int            start_cycles = 0;
   int            start_wait = 0;
   int            inv_hs = 0;
   int            inv_wait = 0;
   bit            done_seen = 1'b0;
   logic [15:0]   done_len = '0;
   logic [1:0]    done_err = '0;
   bit            multi_en = 1'b0;
   bit            stall_bad = 1'b0;
   bit            slot_bad = 1'b0;
   bit            prev_stall = 1'b0;
   logic [8:0]    prev_beat = '0;
   logic [SW-1:0] cur_slot = '0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // PRT and sink model: words appear the cycle after a fetch, ack pulses follow the EN_* requests.
   initial begin
      forever begin
         @(negedge CLK);
         cyc++;
         if (pend_fetch && RST_N) begin
            if (fidx < src_len)    read_prt_entry = {1'b0, src[fidx]};
            else if (src_complete) read_prt_entry = {1'b1, 8'($urandom)};
            else                   read_prt_entry = {1'b0, 8'($urandom)};
            fidx++;
         end else begin
            read_prt_entry = 9'($urandom);
         end
         pend_fetch = 1'b0;
         case (tready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 4 == 0);
            default: m_tready = ($urandom_range(0, 2) != 0);
         endcase
         RDY_read_prt_entry = ($urandom_range(0, 3) != 0);
         #1;
         RDY_start_reading_prt_entry = 1'b0;
         RDY_invalidate_prt_entry    = 1'b0;
         if (!RST_N) begin
            prev_stall = 1'b0;
         end else begin
            if (int'(EN_read_prt_entry) + int'(EN_start_reading_prt_entry) + int'(EN_invalidate_prt_entry) > 1)
               multi_en = 1'b1;
            if (EN_read_prt_entry) pend_fetch = 1'b1;
            if (EN_start_reading_prt_entry) begin
               start_cycles++;
               if (start_reading_prt_entry_slot !== cur_slot) slot_bad = 1'b1;
               if (start_delay >= 0 && start_wait == start_delay) RDY_start_reading_prt_entry = 1'b1;
               start_wait++;
            end
            if (EN_invalidate_prt_entry) begin
               if (invalidate_prt_entry_slot !== cur_slot) slot_bad = 1'b1;
               if (inv_wait == 0) begin
                  RDY_invalidate_prt_entry = 1'b1;
                  inv_hs++;
                  inv_wait = $urandom_range(0, 2);
               end else begin
                  inv_wait--;
               end
            end
            if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} !== prev_beat)) stall_bad = 1'b1;
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
               if (beat_idx < n_exp) begin
                  checkOutput("beat_data", 32'(m_tdata), 32'(src[beat_idx]));
                  checkOutput("beat_last", 32'(m_tlast), 32'(beat_idx == n_exp - 1));
               end else begin
                  checkOutput("extra_beat", 32'(beat_idx + 1), 32'(n_exp));
               end
               beat_idx++;
            end
            if (tx_done) begin
               done_seen = 1'b1;
               done_len  = tx_len;
               done_err  = tx_err;
            end
         end
      end
   end

   // Reference: a frame yields its bytes up to the limit; missing complete or hitting the limit is oversize.
   task automatic startTxn(input int slot, input int len, input bit complete, input int sdelay,
                           input int tmode, input bit fixed);
      @(negedge CLK);
      #3;
      for (int i = 0; i < len; i++) src[i] = fixed ? 8'(8'h11 + i) : 8'($urandom);
      src_len = len; src_complete = complete; start_delay = sdelay; tready_mode = tmode;
      fidx = 0; beat_idx = 0; start_cycles = 0; start_wait = 0; inv_hs = 0;
      inv_wait = $urandom_range(0, 2);
      done_seen = 1'b0; multi_en = 1'b0; stall_bad = 1'b0; slot_bad = 1'b0;
      cur_slot = SW'(slot);
      if (sdelay < 0) begin
         n_exp = 0; exp_err = 1; exp_inv = 0;
      end else if (!complete || len >= MAXF) begin
         n_exp = MAXF; exp_err = 2; exp_inv = 1;
      end else begin
         n_exp = len; exp_err = 0; exp_inv = 1;
      end
      tx_req_slot  = SW'(slot);
      tx_req_valid = 1'b1;
      checkOutput("req_ready", 32'(tx_req_ready), 32'd1);
      @(negedge CLK);
      #3;
      tx_req_valid = 1'b0;
   endtask

   task automatic applyStimulus(input int slot, input int len, input bit complete, input int sdelay,
                                input int tmode, input bit fixed);
      int cycles;
      startTxn(slot, len, complete, sdelay, tmode, fixed);
      cycles = 0;
      while (!done_seen && cycles < 20000) begin
         @(negedge CLK);
         cycles++;
      end
      checkOutput("done_seen", 32'(done_seen), 32'd1);
      checkOutput("tx_len", 32'(done_len), 32'(n_exp));
      checkOutput("tx_err", 32'(done_err), 32'(exp_err));
      checkOutput("beat_count", 32'(beat_idx), 32'(n_exp));
      checkOutput("inval_count", 32'(inv_hs), 32'(exp_inv));
      checkOutput("one_en", 32'(multi_en), 32'd0);
      checkOutput("stall_stable", 32'(stall_bad), 32'd0);
      checkOutput("slot_out", 32'(slot_bad), 32'd0);
      if (sdelay < 0) checkOutput("start_cycles", 32'(start_cycles), 32'(TOUT));
      repeat (2) @(negedge CLK);
      #3;
      checkOutput("idle_ready", 32'(tx_req_ready), 32'd1);
   endtask

   initial begin
      int cycles;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      #1;
      checkOutput("rst_ready", 32'(tx_req_ready), 32'd1);
      checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("rst_en", 32'({EN_start_reading_prt_entry, EN_read_prt_entry, EN_invalidate_prt_entry}), 32'd0);
      checkOutput("rst_done", 32'(tx_done), 32'd0);
      checkOutput("rst_len", 32'(tx_len), 32'd0);
      checkOutput("rst_err", 32'(tx_err), 32'd0);
      checkOutput("rst_slots", 32'({start_reading_prt_entry_slot, invalidate_prt_entry_slot}), 32'd0);

      applyStimulus(1, 5, 1'b1, 0, 0, 1'b1);
      applyStimulus(1, 5, 1'b1, 2, 1, 1'b1);
      applyStimulus(0, 0, 1'b1, 1, 0, 1'b0);
      applyStimulus(1, 3, 1'b1, -1, 0, 1'b0);
      applyStimulus(0, 1600, 1'b0, 0, 2, 1'b0);

      // Reset in the middle of a frame, then a clean frame.
      startTxn(1, 5, 1'b1, 0, 0, 1'b1);
      cycles = 0;
      while (beat_idx < 3 && cycles < 2000) begin
         @(negedge CLK);
         cycles++;
      end
      checkOutput("mid_frame_reached", 32'(beat_idx >= 3), 32'd1);
      RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      #3;
      checkOutput("rst_mid_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("rst_mid_ready", 32'(tx_req_ready), 32'd1);
      checkOutput("rst_mid_en", 32'({EN_start_reading_prt_entry, EN_read_prt_entry, EN_invalidate_prt_entry}), 32'd0);
      repeat (4) @(negedge CLK);
      checkOutput("rst_mid_no_inval", 32'(inv_hs), 32'd0);
      checkOutput("rst_mid_no_done", 32'(done_seen), 32'd0);
      applyStimulus(0, 5, 1'b1, 0, 0, 1'b1);

      for (int t = 0; t < 10; t++)
         applyStimulus($urandom_range(0, 1), $urandom_range(0, 40), 1'b1, $urandom_range(0, 4), 2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prt_tx_drain.md
PRT_TX_DRAIN -- requirements
Module: prt_tx_drain

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: DATA_WIDTH 8, byte width; NUM_SLOTS 2, PRT slot count; SLOT_WIDTH $clog2(NUM_SLOTS), slot index width; MAX_FRAME 1518, frame byte limit; FIFO_DEPTH 4, output buffer entries (power of 2); START_TIMEOUT 16, cycles allowed for RDY_start_reading_prt_entry.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- tx_req_valid  in  1  request to transmit one slot.
- tx_req_slot  in  SLOT_WIDTH  slot to transmit.
- tx_req_ready  out  1  request accepted when valid&ready.
- EN_start_reading_prt_entry  out  1  PRT read-start request.
- start_reading_prt_entry_slot  out  SLOT_WIDTH  slot being read.
- RDY_start_reading_prt_entry  in  1  PRT read-start acknowledge (1-cycle pulse).
- EN_read_prt_entry  out  1  fetch one word.
- RDY_read_prt_entry  in  1  PRT can supply words.
- read_prt_entry  in  DATA_WIDTH+1  {complete, data}, valid the cycle after a fetch.
- EN_invalidate_prt_entry  out  1  PRT slot-release request.
- invalidate_prt_entry_slot  out  SLOT_WIDTH  slot to release.
- RDY_invalidate_prt_entry  in  1  invalidate acknowledge (1-cycle pulse).
- m_tdata  out  DATA_WIDTH  egress byte.
- m_tvalid  out  1  egress byte valid.
- m_tlast  out  1  last byte of frame.
- m_tready  in  1  egress sink ready.
- tx_done  out  1  1-cycle pulse, frame fully handled.
- tx_len  out  16  bytes emitted for finished frame, valid with tx_done.
- tx_err  out  2  with tx_done: 0 ok, 1 start timeout, 2 oversize.

Function
REQ-003 FSM states SHALL be IDLE, START, FETCH, FLUSH, INVAL, DONE.
REQ-004 IDLE: tx_req_ready=1; on tx_req_valid latch slot, clear byte counter, timeout counter and error, go START.
REQ-005 START: EN_start_reading_prt_entry=1 with latched slot; on RDY_start_reading_prt_entry go FETCH; if START_TIMEOUT cycles elapse without it, set tx_err=1, go DONE (no invalidate).
REQ-006 FETCH: EN_read_prt_entry=RDY_read_prt_entry && (fifo_count + inflight < FIFO_DEPTH); each issued fetch returns read_prt_entry exactly one cycle later.
REQ-007 Returned word with complete=0 SHALL be held in a 1-word staging register; the previously staged byte is pushed to the FIFO with last=0.
REQ-008 Returned word with complete=1 SHALL push the staged byte (if any) with last=1, stop fetching, go FLUSH; ignore its data bits.
REQ-009 complete=1 on the first returned word (zero-length frame) SHALL emit no bytes, tx_len=0, tx_err=0.
REQ-010 When the byte counter reaches MAX_FRAME without complete, the MAX_FRAME-th byte SHALL be pushed with last=1, fetching stops, tx_err=2, go FLUSH.
REQ-011 Egress: m_tvalid = FIFO non-empty; m_tdata/m_tlast = FIFO head; pop on m_tvalid&m_tready; m_tdata/m_tlast held stable while m_tvalid&!m_tready.
REQ-012 FLUSH: wait until FIFO empty and no fetch in flight, go INVAL.
REQ-013 INVAL: EN_invalidate_prt_entry=1 with latched slot until RDY_invalidate_prt_entry, then DONE.
REQ-014 DONE: tx_done=1 one cycle with tx_len and tx_err, then IDLE; tx_req_ready=0 in all states except IDLE.
REQ-015 tx_len SHALL count popped bytes, 16-bit, saturating (never wraps).
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH; push and pop in the same cycle when full or empty SHALL be legal and keep the count unchanged.
REQ-017 At most one PRT EN_* output SHALL be high in any cycle.

Reset
REQ-018 RST_N=0 sampled at a CLK edge SHALL return to IDLE, empty the FIFO, clear staging, counters and errors.
REQ-019 Reset values SHALL be all outputs 0, except tx_req_ready=1 and slot outputs 0; reset mid-frame discards buffered bytes and issues no invalidate.

Verification
REQ-020 Slot 1 holds 5 bytes 0x11..0x15, m_tready=1 -> 5 beats in order, m_tlast only on 0x15, invalidate slot 1, tx_done with tx_len=5, tx_err=0.
REQ-021 Same frame, m_tready toggled 1-cycle-on/3-off -> identical byte order, stable m_tdata during stall, FIFO never exceeds 4.
REQ-022 First returned word complete=1 -> no m_tvalid, invalidate issued, tx_len=0, tx_err=0.
REQ-023 RDY_start_reading_prt_entry never asserted -> tx_done after 16 START cycles, tx_err=1, no EN_invalidate_prt_entry.
REQ-024 1600-byte source without complete -> 1518 beats, m_tlast on beat 1518, tx_len=1518, tx_err=2, invalidate issued.
REQ-025 RST_N low 2 cycles mid-frame (beat 3 of 5) -> m_tvalid=0 next cycle, IDLE, tx_req_ready=1, next request transmits cleanly.
